// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: lane geometry and the write-back bundle layout
// used by the commit buffer and the multi-port register file.
package pipe_pkg;

    localparam int PARALLEL_ORDER = 4;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam int REG_ENTRY      = 2 ** REG_ADDR_WIDTH;

    typedef struct packed {
        logic [PARALLEL_ORDER-1:0]                     lane_valid;
        logic [PARALLEL_ORDER-1:0][REG_ADDR_WIDTH-1:0] addr;
        logic [PARALLEL_ORDER-1:0][REG_DATA_WIDTH-1:0] data;
    } wb_bundle_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back bundles; exposes every slot plus an
// occupied-slot mask so the parent can build the pending-write bitmap.
module wb_fifo
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  wb_bundle_t                   push_data,
    input  logic                         pop,
    output wb_bundle_t                   head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output wb_bundle_t [DEPTH-1:0]       entries,
    output logic [DEPTH-1:0]             entry_valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_bundle_t [DEPTH-1:0] mem;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign entries = mem;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) mem[wr_ptr] <= push_data;
    end

    always_comb begin
        logic [PTR_W-1:0] offset;
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset         = PTR_W'(i) - rd_ptr;
            entry_valid[i] = (CNT_W'(offset) < count);
        end
    end

endmodule

// File: rtl/wb_commit_buffer.sv
// Write-back commit buffer: queues result bundles and drives the register
// file write ports one bundle per cycle, exporting a pending-write bitmap.
module wb_commit_buffer
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [PARALLEL_ORDER-1:0]                     in_lane_valid,
    input  logic [PARALLEL_ORDER-1:0][REG_ADDR_WIDTH-1:0] in_addr,
    input  logic [PARALLEL_ORDER-1:0][REG_DATA_WIDTH-1:0] in_data,
    input  logic                                          hold,
    input  logic                                          flush,
    output logic [PARALLEL_ORDER-1:0]                     w_valid,
    output logic [PARALLEL_ORDER-1:0][REG_ADDR_WIDTH-1:0] w_addr,
    output logic [PARALLEL_ORDER-1:0][REG_DATA_WIDTH-1:0] w_data,
    output logic [REG_ENTRY-1:0]                          pending,
    output logic [$clog2(DEPTH+1)-1:0]                    occupancy
);

    wb_bundle_t             in_bundle;
    wb_bundle_t             head;
    wb_bundle_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]       entry_valid;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;

    assign in_bundle = {in_lane_valid, in_addr, in_data};
    assign in_ready  = !rst && !flush && !full;
    // All-zero bundles complete the handshake but are never stored.
    assign push      = in_valid && in_ready && (|in_lane_valid);
    assign pop       = !hold && !empty && !rst && !flush;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .push        (push),
        .push_data   (in_bundle),
        .pop         (pop),
        .head        (head),
        .full        (full),
        .empty       (empty),
        .count       (occupancy),
        .entries     (entries),
        .entry_valid (entry_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            w_valid <= '0;
            w_addr  <= '0;
            w_data  <= '0;
        end else if (pop) begin
            w_valid <= head.lane_valid;
            w_addr  <= head.addr;
            w_data  <= head.data;
        end else begin
            w_valid <= '0;
        end
    end

    always_comb begin
        pending = '0;
        for (int e = 0; e < DEPTH; e++) begin
            for (int l = 0; l < PARALLEL_ORDER; l++) begin
                if (entry_valid[e] && entries[e].lane_valid[l])
                    pending[entries[e].addr[l]] = 1'b1;
            end
        end
        for (int l = 0; l < PARALLEL_ORDER; l++) begin
            if (w_valid[l]) pending[w_addr[l]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_commit_buffer.sv
// Scoreboard bench for wb_commit_buffer: accepted bundles are queued as
// expectations and compared against each w_* presentation.
module tb_wb_commit_buffer;
    import pipe_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic hold = 1'b0;
    logic flush = 1'b0;
    wb_bundle_t drv = '0;
    logic in_ready;
    logic [PARALLEL_ORDER-1:0]                     w_valid;
    logic [PARALLEL_ORDER-1:0][REG_ADDR_WIDTH-1:0] w_addr;
    logic [PARALLEL_ORDER-1:0][REG_DATA_WIDTH-1:0] w_data;
    logic [REG_ENTRY-1:0]                          pending;
    logic [$clog2(DEPTH+1)-1:0]                    occupancy;

    wb_bundle_t sb_q[$];
    logic [REG_DATA_WIDTH-1:0] rf [REG_ENTRY];
    int n_checks = 0;
    int n_errors = 0;
    bit acc;

    always #5 clk = ~clk;

    wb_commit_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_lane_valid (drv.lane_valid),
        .in_addr       (drv.addr),
        .in_data       (drv.data),
        .hold          (hold),
        .flush         (flush),
        .w_valid       (w_valid),
        .w_addr        (w_addr),
        .w_data        (w_data),
        .pending       (pending),
        .occupancy     (occupancy)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic wb_bundle_t rand_bundle();
        wb_bundle_t b;
        b.lane_valid = 4'($urandom_range(1, 15));
        for (int l = 0; l < PARALLEL_ORDER; l++) begin
            b.addr[l] = 5'($urandom);
            b.data[l] = $urandom;
        end
        return b;
    endfunction

    // One clock: record acceptance, advance, update model, check any commit.
    task automatic step(output bit accepted);
        bit a, clr;
        wb_bundle_t d, e;
        logic [PARALLEL_ORDER-1:0] pv;
        logic [PARALLEL_ORDER-1:0][REG_ADDR_WIDTH-1:0] pa;
        logic [PARALLEL_ORDER-1:0][REG_DATA_WIDTH-1:0] pd;
        a = in_valid && in_ready;
        clr = rst || flush;
        d = drv;
        pv = w_valid; pa = w_addr; pd = w_data;
        @(posedge clk);
        #1;
        for (int l = 0; l < PARALLEL_ORDER; l++)
            if (pv[l]) rf[pa[l]] = pd[l];
        if (clr) sb_q.delete();
        if (a && (|d.lane_valid)) sb_q.push_back(d);
        if (w_valid != '0) begin
            if (sb_q.size() == 0) begin
                check("unexpected_commit", w_valid, 0);
            end else begin
                e = sb_q.pop_front();
                check("commit", {w_valid, w_addr, w_data}, e);
            end
        end
        accepted = a;
    endtask

    initial begin
        // reset
        step(acc);
        check("rst_in_ready", in_ready, 0);
        step(acc);
        rst = 1'b0;
        #1;
        check("rst_w_valid", w_valid, 0);
        check("rst_w_addr", w_addr, 0);
        check("rst_w_data", w_data, 0);
        check("rst_occ", occupancy, 0);
        check("rst_pending", pending, 0);
        check("rst_in_ready_after", in_ready, 1);

        // single bundle, lanes 0 and 2
        drv = '0;
        drv.lane_valid = 4'b0101;
        drv.addr[0] = 5'd3;  drv.data[0] = 32'hA;
        drv.addr[2] = 5'd7;  drv.data[2] = 32'hB;
        in_valid = 1'b1;
        step(acc);
        check("single_acc", acc, 1);
        in_valid = 1'b0;
        check("single_wv_k", w_valid, 0);
        check("single_pend3_q", pending[3], 1);
        check("single_pend7_q", pending[7], 1);
        step(acc);
        check("single_wv_k1", w_valid, 4'b0101);
        check("single_pend_stage", pending, (32'h1 << 3) | (32'h1 << 7));
        step(acc);
        check("single_wv_k2", w_valid, 0);
        check("single_pend_clear", pending, 0);
        check("single_drain", sb_q.size(), 0);

        // fill under hold, stall 5th, release
        hold = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drv = rand_bundle();
            in_valid = 1'b1;
            step(acc);
            check("fill_acc", acc, 1);
        end
        drv = rand_bundle();
        check("full_occ", occupancy, DEPTH);
        check("full_in_ready", in_ready, 0);
        step(acc);
        check("full_stall", acc, 0);
        check("hold_no_wv", w_valid, 0);
        hold = 1'b0;
        step(acc);
        check("release_no_acc", acc, 0);
        check("release_wv", |w_valid, 1);
        check("release_ready", in_ready, 1);
        step(acc);
        check("fifth_acc", acc, 1);
        in_valid = 1'b0;
        check("release_wv2", |w_valid, 1);
        for (int i = 0; i < 3; i++) begin
            step(acc);
            check("release_no_bubble", |w_valid, 1);
        end
        step(acc);
        check("release_drain", sb_q.size(), 0);
        check("release_idle", w_valid, 0);

        // continuous stream
        for (int i = 0; i < 12; i++) begin
            drv = rand_bundle();
            in_valid = 1'b1;
            step(acc);
            check("stream_occ", occupancy, 1);
            if (i > 0) check("stream_no_bubble", |w_valid, 1);
        end
        in_valid = 1'b0;
        step(acc);
        check("stream_last", |w_valid, 1);
        check("stream_occ_end", occupancy, 0);
        check("stream_drain", sb_q.size(), 0);

        // same-address lanes
        drv.lane_valid = 4'b1111;
        for (int l = 0; l < PARALLEL_ORDER; l++) begin
            drv.addr[l] = 5'd5;
            drv.data[l] = 32'(l + 1);
        end
        in_valid = 1'b1;
        step(acc);
        in_valid = 1'b0;
        step(acc);
        check("same_wv", w_valid, 4'b1111);
        step(acc);
        check("same_rf5", rf[5], 32'd4);

        // all-zero bundle
        drv = rand_bundle();
        drv.lane_valid = '0;
        in_valid = 1'b1;
        check("zero_ready", in_ready, 1);
        step(acc);
        in_valid = 1'b0;
        check("zero_acc", acc, 1);
        check("zero_occ", occupancy, 0);
        for (int i = 0; i < 3; i++) begin
            step(acc);
            check("zero_no_wv", w_valid, 0);
        end

        // flush, then reset, with 3 queued
        for (int pass = 0; pass < 2; pass++) begin
            hold = 1'b1;
            for (int i = 0; i < 3; i++) begin
                drv = rand_bundle();
                in_valid = 1'b1;
                step(acc);
            end
            check("kill_occ3", occupancy, 3);
            drv = rand_bundle();
            if (pass == 0) flush = 1'b1; else rst = 1'b1;
            #1;
            check("kill_ready", in_ready, 0);
            step(acc);
            flush = 1'b0;
            rst = 1'b0;
            hold = 1'b0;
            check("kill_acc", acc, 0);
            check("kill_occ", occupancy, 0);
            check("kill_pending", pending, 0);
            check("kill_wv", w_valid, 0);
            in_valid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                step(acc);
                check("kill_no_wv", w_valid, 0);
            end
        end
        check("final_drain", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
